// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings, LED constants and pattern helpers for the LED pattern controller.
package led_ctrl_pkg;

  localparam int LED_W = 4;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_PASS  = 2'b00;
  localparam mode_t MODE_BLINK = 2'b01;
  localparam mode_t MODE_CHASE = 2'b10;
  localparam mode_t MODE_COUNT = 2'b11;

  localparam logic [LED_W-1:0] CHASE_INIT = 4'b0001;
  localparam logic [LED_W-1:0] ALL_ON     = 4'b1111;

  // Pattern loaded on the edge a new mode takes effect.
  function automatic logic [LED_W-1:0] init_pattern(input mode_t m, input logic [LED_W-1:0] db);
    logic [LED_W-1:0] r;
    case (m)
      MODE_CHASE: r = CHASE_INIT;
      MODE_PASS:  r = db;
      default:    r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [LED_W-1:0] next_pattern(input mode_t m, input logic [LED_W-1:0] cur);
    logic [LED_W-1:0] r;
    case (m)
      MODE_BLINK: r = cur ^ ALL_ON;
      MODE_CHASE: r = {cur[LED_W-2:0], cur[LED_W-1]};
      MODE_COUNT: r = cur + 1'b1;
      default:    r = cur;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a per-bit stability counter; a bit changes only
// after its synchronised value has differed from the debounced value for DEBOUNCE_CYCLES edges.
module switch_debounce
  import led_ctrl_pkg::*;
#(
  parameter int W               = LED_W,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] db
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]  s1;
  logic [W-1:0]  s2;
  logic [CW-1:0] cnt [W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      for (int i = 0; i < W; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < W; i++) begin
        // Any sample agreeing with the debounced value discards a pending change.
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Switch-driven LED controller: debounced switches select a mode (sw_db[3:2]) and a
// speed (sw_db[1:0]); a tick prescaler and step counter pace the pattern sequencer.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TICK_DIV        = 12500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LED_W-1:0] switches,
  output logic [LED_W-1:0] leds,
  output logic [LED_W-1:0] sw_db,
  output mode_t            mode,
  output logic             step
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic [2:0]    stepcnt;
  logic [2:0]    step_thr;
  logic          tick;

  switch_debounce #(
    .W               (LED_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .raw (switches),
    .db  (sw_db)
  );

  assign tick     = (presc == PRE_LAST);
  assign step_thr = 3'((4'd1 << sw_db[1:0]) - 4'd1);

  // A mode change restarts pacing and wins over any step due on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      stepcnt <= '0;
      mode    <= MODE_PASS;
      leds    <= '0;
      step    <= 1'b0;
    end else begin
      step <= 1'b0;
      if (sw_db[3:2] != mode) begin
        mode    <= sw_db[3:2];
        presc   <= '0;
        stepcnt <= '0;
        leds    <= init_pattern(sw_db[3:2], sw_db);
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          if (stepcnt >= step_thr) begin
            stepcnt <= '0;
            step    <= 1'b1;
            if (mode != MODE_PASS) leds <= next_pattern(mode, leds);
          end else begin
            stepcnt <= stepcnt + 1'b1;
          end
        end
        if (mode == MODE_PASS) leds <= sw_db;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed and random switch sequences scored cycle by cycle
// against a reference model built from switch history windows and edge counting.
module tb_led_pattern_ctrl;

  localparam int DB = 4;
  localparam int TD = 3;
  localparam int W  = 11;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] switches;
  logic [3:0] leds;
  logic [3:0] sw_db;
  logic [1:0] mode;
  logic       step;

  led_pattern_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .TICK_DIV        (TD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .switches (switches),
    .leds     (leds),
    .sw_db    (sw_db),
    .mode     (mode),
    .step     (step)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  logic [3:0]   raw_q[$];
  logic [3:0]   win_q[$];
  logic [3:0]   m_db;
  logic [3:0]   m_leds;
  logic [1:0]   m_mode;
  logic         m_step;
  int unsigned  edge_k;
  int unsigned  restart_k;
  int           ticks_acc;

  task automatic model_reset();
    m_db = '0; m_leds = '0; m_mode = '0; m_step = 1'b0;
    raw_q.delete();
    raw_q.push_back(4'h0);
    raw_q.push_back(4'h0);
    win_q.delete();
    edge_k = 0; restart_k = 0; ticks_acc = 0;
  endtask

  function automatic logic [3:0] advance(input logic [1:0] m, input logic [3:0] cur);
    int v;
    v = int'(cur);
    case (m)
      2'b01:   v = 15 - v;
      2'b10:   v = (v == 8) ? 1 : v * 2;
      2'b11:   v = (v + 1) % 16;
      default: v = v;
    endcase
    return 4'(v);
  endfunction

  // One clock edge seen with raw switch value 'raw' applied before it.
  task automatic model_edge(input logic [3:0] raw);
    logic [3:0] s2;
    logic [3:0] new_db;
    bit         all_diff;
    edge_k++;
    raw_q.push_back(raw);
    s2 = raw_q.pop_front();
    win_q.push_back(s2);
    if (win_q.size() > DB) void'(win_q.pop_front());
    new_db = m_db;
    if (win_q.size() == DB) begin
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        foreach (win_q[j]) if (win_q[j][i] == m_db[i]) all_diff = 1'b0;
        if (all_diff) new_db[i] = ~m_db[i];
      end
    end
    m_step = 1'b0;
    if (m_db[3:2] != m_mode) begin
      m_mode    = m_db[3:2];
      restart_k = edge_k;
      ticks_acc = 0;
      case (m_mode)
        2'b10:   m_leds = 4'b0001;
        2'b00:   m_leds = m_db;
        default: m_leds = 4'b0000;
      endcase
    end else begin
      if (((edge_k - restart_k) % TD) == 0) begin
        ticks_acc++;
        if (ticks_acc >= (1 << m_db[1:0])) begin
          ticks_acc = 0;
          m_step    = 1'b1;
          m_leds    = advance(m_mode, m_leds);
        end
      end
      if (m_mode == 2'b00) m_leds = m_db;
    end
    m_db = new_db;
    exp_q.push_back({m_db, m_mode, m_leds, m_step});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {sw_db, mode, leds, step};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle_check t=%0t: got sw_db=%b mode=%b leds=%b step=%b, expected sw_db=%b mode=%b leds=%b step=%b",
                 $time, a[10:7], a[6:5], a[4:1], a[0], e[10:7], e[6:5], e[4:1], e[0]);
      end
    end
  end

  // ---------------- driver tasks (start and end just after a negedge) ----------------
  task automatic check_zero(input string name);
    n_cmp++;
    if ({sw_db, mode, leds, step} !== 11'd0) begin
      n_bad++;
      $display("FAIL %s: got sw_db=%b mode=%b leds=%b step=%b, expected all zero",
               name, sw_db, mode, leds, step);
    end
  endtask

  task automatic hold(input logic [3:0] sw, input int n);
    repeat (n) begin
      switches = sw;
      @(posedge clk);
      model_edge(sw);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check_zero("async_reset");
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1 check_zero("after_release");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    switches = 4'h0;
    model_reset();
    @(negedge clk);
    do_reset();

    hold(4'b0000, 5);
    hold(4'b0011, 12);
    hold(4'b0001, 3);
    hold(4'b0000, 10);
    hold(4'b0001, 4);
    hold(4'b0000, 12);
    hold(4'b1000, 30);
    hold(4'b1101, 110);
    hold(4'b1101, 7);
    do_reset();
    hold(4'b0100, 30);
    hold(4'b1000, 20);
    hold(4'b0010, 20);

    for (int s = 0; s < 70; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_reset();
      end else begin
        hold(4'($urandom_range(0, 15)), $urandom_range(1, 24));
      end
    end
    hold(switches, 4);

    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Controller for the board's 4 switches / 4 LEDs. It synchronises and debounces the raw switches and decodes them into a mode and a speed. It then drives the LEDs either as a direct pass-through or from an internal tick-paced pattern sequencer. It sits between the board I/O pins and the LED outputs and replaces the direct switch-to-LED wire.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive clk cycles a synchronised switch must differ from its debounced value before the change is accepted (5 ms at 50 MHz); must be >= 2.
TICK_DIV, 12500000, clk cycles per base tick (0.25 s at 50 MHz); must be >= 2.

Ports:
clk  input  1  system clock, the only clock
rst  input  1  asynchronous, active-high reset
switches  input  4  raw board switches, asynchronous to clk
leds  output  4  registered LED drive
sw_db  output  4  debounced switch value
mode  output  2  registered active mode
step  output  1  one-cycle pulse on each pattern advance

Behaviour:
- Reset: asynchronous assert; all flops clear.
  - Outputs: leds=0000, sw_db=0000, mode=00, step=0.
  - Internal state: sync flops, debounce counters, prescaler, step counter and pattern all 0.
- Synchroniser: 2 flops per bit; the second stage is s2.
- Debounce, per bit with counter cnt:
  - If s2==sw_db[i], cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1, sw_db[i]<=s2 and cnt<=0.
  - Else cnt<=cnt+1.
  - Any return to the old value before acceptance discards the change.
- Decode: mode source = sw_db[3:2]; speed = sw_db[1:0].
- Mode encodings:
  - 00 PASS: leds<=sw_db every cycle.
  - 01 BLINK: leds alternate 0000/1111.
  - 10 CHASE: rotate left, 0001->0010->0100->1000->0001.
  - 11 COUNT: binary +1 mod 16; 1111 wraps to 0000.
- Mode change: on the edge where sw_db[3:2]!=mode:
  - mode<=sw_db[3:2].
  - Prescaler and step counter cleared; step=0 that cycle.
  - leds<=initial pattern: BLINK 0000, CHASE 0001, COUNT 0000, PASS sw_db.
- Tick: prescaler counts 0..TICK_DIV-1, wraps, and raises an internal tick on its wrap cycle. It runs in all modes.
- Step: on tick, if stepcnt >= (1<<speed)-1, then stepcnt<=0 and a step occurs. Otherwise stepcnt<=stepcnt+1.
  - Steps occur every 1,2,4,8 ticks for speed 0..3.
  - A step registers step=1 for one cycle and advances the pattern in leds on the same edge.
  - In PASS, steps still pulse step but leds are unaffected.
- Speed change: pattern, prescaler and stepcnt are not reset. The >= compare ensures a step on the next tick when stepcnt exceeds the new threshold.
- Simultaneous events: a mode change takes priority over a step on the same edge; the step is dropped.
- Latency: a raw switch change is visible on leds (PASS) or triggers a mode change exactly DEBOUNCE_CYCLES+3 edges later.
- Reset mid-operation: immediate clear. After release, operation is PASS with leds following sw_db, which starts at 0000.

Decomposition:
- Package led_ctrl_pkg:
  - Mode localparams MODE_PASS=2'b00, MODE_BLINK=2'b01, MODE_CHASE=2'b10, MODE_COUNT=2'b11.
  - LED width 4; initial patterns CHASE_INIT=4'b0001, ALL_ON=4'b1111.
- Sub-module switch_debounce, parameterised by width and DEBOUNCE_CYCLES. It contains the synchroniser plus per-bit counters and is instantiated once for all 4 bits.
- Prescaler, step counter and pattern logic stay in the top.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=3):
1. Reset: assert rst asynchronously mid-COUNT with leds=0101 -> leds, sw_db, mode all 0 before the next clk edge; after release leds=0000.
2. Pass-through: switches 0000->0011 held -> sw_db=0011 at edge 6 and leds=0011 at edge 7 after the change; no change before.
3. Glitch reject: switches[0] high for 3 cycles then low -> sw_db and leds stay 0000; a 4-cycle-stable pulse is accepted.
4. Chase: switches=1000 -> mode=10 and leds=0001 at edge 7; then step pulses every 3 cycles with leds 0010,0100,1000,0001.
5. Count with wrap: switches=1101 (speed 01) -> steps every 6 cycles; leds 0000,0001,...,1111,0000; step high exactly 1 cycle each.
6. Mode change mid-blink with leds=1111 -> leds=0001 on the mode-change edge and no step on that edge; the next step follows 3 cycles later.
